// File: rtl/udp_rx_parser_pkg.sv
// Shared definitions for the UDP receive frame parser: state encoding,
// error codes, header field offsets and the payload byte-enable helper.
package udp_rx_parser_pkg;

  localparam logic [15:0] MAGIC   = 16'hA55A;
  localparam logic [15:0] MAX_LEN = 16'd8192;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  localparam logic [1:0] ERR_HDR   = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;

  // Bit offsets of the fields inside the 64-bit header word; [63:56] is reserved.
  localparam int HDR_MAGIC_LSB = 0;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_LEN_LSB   = 32;
  localparam int HDR_TYPE_LSB  = 48;

  // Byte enables for a payload word given the bytes still owed by the frame.
  function automatic logic [7:0] keep_mask(input logic [15:0] rem);
    logic [3:0] sh;
    sh = 4'd8 - rem[3:0];
    if (rem >= 16'd8) return 8'hFF;
    return 8'hFF >> sh;
  endfunction

endpackage

// File: rtl/udp_rx_out_reg.sv
// Single-entry output register carrying one payload word with its
// byte enables and frame markers. Fields hold until valid && ready.
// The parent only asserts load_i when the slot is empty or draining.
module udp_rx_out_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  keep_i,
  input  logic        last_i,
  input  logic        user_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [63:0] data_o,
  output logic [7:0]  keep_o,
  output logic        last_o,
  output logic        user_o
);

  // Capture a new word on load, otherwise empty the slot when it is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      keep_o  <= '0;
      last_o  <= 1'b0;
      user_o  <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      keep_o  <= keep_i;
      last_o  <= last_i;
      user_o  <= user_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/udp_rx_frame_parser.sv
// Application frame parser downstream of the UDP receive path.
// Strips and validates the 8-byte header, forwards payload with byte
// enables, and reports per-frame status, sequence gaps and counters.
// Optional feature: define UDP_RX_PARSER_SEQ_CHECK_EN to build the
// sequence tracker; otherwise seq_gap is tied low.
//
// Handshake rule (both ports): a word moves on a rising edge where
// valid && ready are both high; a raised valid and its payload hold
// until that happens.
module udp_rx_frame_parser
  import udp_rx_parser_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [63:0] m_data,
  output logic [7:0]  m_keep,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_user,
  input  logic        m_ready,
  output logic [7:0]  m_type,
  output logic [15:0] m_seq,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        seq_gap,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt,
  output logic [1:0]  dbg_state_o
);

  state_e      state_q;
  logic [15:0] rem_q;
  logic [1:0]  err_q;

  logic [15:0] hdr_magic, hdr_seq, hdr_len;
  logic [7:0]  hdr_type;
  logic        hdr_magic_ok, hdr_bad;
  logic        s_acc, hdr_acc, out_load;
  logic        rem_le8, out_last, out_user;

  assign hdr_magic    = s_data[HDR_MAGIC_LSB +: 16];
  assign hdr_seq      = s_data[HDR_SEQ_LSB +: 16];
  assign hdr_len      = s_data[HDR_LEN_LSB +: 16];
  assign hdr_type     = s_data[HDR_TYPE_LSB +: 8];
  assign hdr_magic_ok = (hdr_magic == MAGIC);
  assign hdr_bad      = !hdr_magic_ok || (hdr_len > MAX_LEN);

  // Input ready: payload waits on the output slot; a new header waits
  // until the previous frame's final word has left the output register.
  always_comb begin
    s_ready = 1'b1;
    case (state_q)
      ST_PAYLOAD: s_ready = !m_valid || m_ready;
      ST_HDR:     s_ready = !(m_valid && !m_ready && m_last);
      default:    s_ready = 1'b1;
    endcase
  end

  assign s_acc    = s_valid && s_ready;
  assign hdr_acc  = s_acc && (state_q == ST_HDR);
  assign out_load = s_acc && (state_q == ST_PAYLOAD);
  assign rem_le8  = (rem_q <= 16'd8);
  // A word closes the frame if the input ends or the length is exhausted;
  // it is flagged bad unless both happen together.
  assign out_last = s_last || rem_le8;
  assign out_user = out_last && !(s_last && rem_le8);

  assign dbg_state_o = state_q;

  // Frame FSM with registered status pulses, header fields and counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_HDR;
      rem_q      <= '0;
      err_q      <= ERR_HDR;
      m_type     <= '0;
      m_seq      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (hdr_acc) begin
        m_type <= hdr_type;
        m_seq  <= hdr_seq;
        rem_q  <= hdr_len;
        if (hdr_bad) begin
          if (s_last) begin
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
            err_code   <= ERR_HDR;
            bad_cnt    <= bad_cnt + 32'd1;
          end else begin
            err_q   <= ERR_HDR;
            state_q <= ST_DROP;
          end
        end else if (hdr_len == 16'd0) begin
          if (s_last) begin
            frame_done <= 1'b1;
            good_cnt   <= good_cnt + 32'd1;
          end else begin
            err_q   <= ERR_LONG;
            state_q <= ST_DROP;
          end
        end else if (s_last) begin
          frame_done <= 1'b1;
          frame_err  <= 1'b1;
          err_code   <= ERR_SHORT;
          bad_cnt    <= bad_cnt + 32'd1;
        end else begin
          state_q <= ST_PAYLOAD;
        end
      end else if (out_load) begin
        rem_q <= rem_le8 ? 16'd0 : (rem_q - 16'd8);
        if (s_last) begin
          frame_done <= 1'b1;
          state_q    <= ST_HDR;
          if (rem_le8) begin
            good_cnt <= good_cnt + 32'd1;
          end else begin
            frame_err <= 1'b1;
            err_code  <= ERR_SHORT;
            bad_cnt   <= bad_cnt + 32'd1;
          end
        end else if (rem_le8) begin
          err_q   <= ERR_LONG;
          state_q <= ST_DROP;
        end
      end else if (s_acc && (state_q == ST_DROP) && s_last) begin
        frame_done <= 1'b1;
        frame_err  <= 1'b1;
        err_code   <= err_q;
        bad_cnt    <= bad_cnt + 32'd1;
        state_q    <= ST_HDR;
      end
    end
  end

  udp_rx_out_reg u_out_reg (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .load_i  (out_load),
    .data_i  (s_data),
    .keep_i  (keep_mask(rem_q)),
    .last_i  (out_last),
    .user_i  (out_user),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .keep_o  (m_keep),
    .last_o  (m_last),
    .user_o  (m_user)
  );

`ifdef UDP_RX_PARSER_SEQ_CHECK_EN
  logic [15:0] exp_seq_q;
  logic        exp_vld_q;
  logic        seq_gap_q;

  // Track the next expected sequence number across well-formed headers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      exp_seq_q <= '0;
      exp_vld_q <= 1'b0;
      seq_gap_q <= 1'b0;
    end else begin
      seq_gap_q <= 1'b0;
      if (hdr_acc && hdr_magic_ok) begin
        exp_vld_q <= 1'b1;
        exp_seq_q <= hdr_seq + 16'd1;
        seq_gap_q <= exp_vld_q && (hdr_seq != exp_seq_q);
      end
    end
  end

  assign seq_gap = seq_gap_q;
`else
  assign seq_gap = 1'b0;
`endif

endmodule

// File: tb/tb_udp_rx_frame_parser.sv
// Self-checking bench for udp_rx_frame_parser: directed frames, a
// frame-level expectation model, a per-cycle compare process and a few
// literal checks.
module tb_udp_rx_frame_parser;

  localparam int OW = 98; // {type8, seq16, user, last, keep8, data64}

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [63:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_valid, m_last, m_user;
  logic        m_ready = 1'b1;
  logic [7:0]  m_type;
  logic [15:0] m_seq;
  logic        frame_done, frame_err, seq_gap;
  logic [1:0]  err_code;
  logic [31:0] good_cnt, bad_cnt;
  logic [1:0]  dbg_state;

  udp_rx_frame_parser dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_user      (m_user),
    .m_ready     (m_ready),
    .m_type      (m_type),
    .m_seq       (m_seq),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .seq_gap     (seq_gap),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];
  logic [2:0]    st_q[$];   // {bad, code}
  logic          gap_q[$];
  logic [15:0]   mdl_exp_seq = '0;
  bit            mdl_have = 0;
  logic [31:0]   mdl_good = '0;
  logic [31:0]   mdl_bad  = '0;
  int            out_seen = 0;
  int            gap_seen = 0;
  logic [1:0]    last_code = '0;
  logic [7:0]    last_keep = '0;
  logic          tb_is_hdr = 1'b0;
  int            rdy_mode  = 0;
  int            fid       = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s act=event exp=none", name);
  endtask

  function automatic logic [63:0] pay_word(input int f, input int i);
    return {16'(f), 16'(i), 32'hC0DE_0000 + 32'(i)};
  endfunction

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      m_ready = (rdy_mode == 1) ? ~m_ready : 1'b1;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [63:0] d, input logic l, input logic h);
    int waitc;
    waitc = 0;
    s_data = d; s_last = l; s_valid = 1'b1; tb_is_hdr = h;
    @(negedge sys_clk);
    while (!s_ready && waitc < 200) begin
      waitc++;
      @(negedge sys_clk);
    end
    if (!s_ready) fail_now("s_ready_timeout");
    @(posedge sys_clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; tb_is_hdr = 1'b0;
  endtask

  // Frame-level model: derives outputs and status from header fields and word count.
  task automatic run_frame(input logic [15:0] magic, input logic [15:0] seq,
                           input logic [15:0] len, input logic [7:0] typ, input int nw);
    int need;
    bit hbad;
    logic [15:0] r;
    logic [7:0] k;
    logic lst;
    logic [2:0] st;
    fid++;
    hbad = (magic != 16'hA55A) || (len > 16'd8192);
    if (magic == 16'hA55A) begin
`ifdef UDP_RX_PARSER_SEQ_CHECK_EN
      gap_q.push_back(mdl_have && (seq != mdl_exp_seq));
`else
      gap_q.push_back(1'b0);
`endif
      mdl_have = 1;
      mdl_exp_seq = seq + 16'd1;
    end else begin
      gap_q.push_back(1'b0);
    end
    need = (int'(len) + 7) / 8;
    if (hbad) st = {1'b1, 2'd0};
    else if (len == 16'd0) st = (nw == 0) ? 3'b000 : {1'b1, 2'd2};
    else if (nw == 0) st = {1'b1, 2'd1};
    else begin
      for (int i = 0; i < nw && i < need; i++) begin
        r = len - 16'(8 * i);
        k = (r >= 16'd8) ? 8'hFF : 8'((1 << r) - 1);
        lst = (i == nw - 1) || (i == need - 1);
        exp_q.push_back({typ, seq, lst && (nw != need), lst, k, pay_word(fid, i)});
      end
      st = (nw == need) ? 3'b000 : ((nw < need) ? {1'b1, 2'd1} : {1'b1, 2'd2});
    end
    st_q.push_back(st);
    send_word({8'hEE, typ, len, seq, magic}, nw == 0, 1'b1);
    for (int i = 0; i < nw; i++) send_word(pay_word(fid, i), i == nw - 1, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && n < 500) begin
      @(posedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0 || st_q.size() != 0) fail_now("idle_timeout");
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  // ---------------- compare process ----------------
  logic          gap_pend = 1'b0;
  logic          gap_bit  = 1'b0;
  logic          stall_prev = 1'b0;
  logic [OW-1:0] held = '0;
  logic [OW-1:0] cur;
  logic [2:0]    st_exp;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        gap_pend = 1'b0;
        stall_prev = 1'b0;
      end else begin
        cur = {m_type, m_seq, m_user, m_last, m_keep, m_data};
        check("seq_gap", seq_gap, gap_pend ? gap_bit : 1'b0);
        if (seq_gap) gap_seen++;
        gap_pend = 1'b0;
        if (s_valid && s_ready && tb_is_hdr) begin
          if (gap_q.size() == 0) fail_now("hdr_unexpected");
          else begin
            gap_bit = gap_q.pop_front();
            gap_pend = 1'b1;
          end
        end
        if (stall_prev) check("stall_hold", {m_valid, cur}, {1'b1, held});
        stall_prev = m_valid && !m_ready;
        held = cur;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) fail_now("out_unexpected");
          else check("out_word", cur, exp_q.pop_front());
          out_seen++;
          last_keep = m_keep;
        end
        if (frame_done) begin
          if (st_q.size() == 0) fail_now("done_unexpected");
          else begin
            st_exp = st_q.pop_front();
            check("frame_status", {frame_err, frame_err ? err_code : 2'b00}, st_exp);
            if (st_exp[2]) mdl_bad = mdl_bad + 32'd1;
            else mdl_good = mdl_good + 32'd1;
          end
          if (frame_err) last_code = err_code;
        end else if (frame_err) begin
          fail_now("err_without_done");
        end
        check("good_cnt", good_cnt, mdl_good);
        check("bad_cnt", bad_cnt, mdl_bad);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int o0, g0, b0;

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_flags", {m_valid, m_last, m_user, frame_done, frame_err, seq_gap}, 6'b0);
    check("rst_fields", {m_data, m_keep, m_type, m_seq, err_code}, '0);
    check("rst_cnts", {good_cnt, bad_cnt}, 64'd0);
    @(posedge sys_clk);
    #1;

    // good frame, 20 bytes in 3 words
    o0 = out_seen;
    run_frame(16'hA55A, 16'd1, 16'd20, 8'd3, 3);
    wait_idle();
    check("t1_outs", out_seen - o0, 3);
    check("t1_keep", last_keep, 8'h0F);
    check("t1_good", good_cnt, 32'd1);

    // bad magic
    o0 = out_seen;
    run_frame(16'h1234, 16'd9, 16'd16, 8'd1, 2);
    wait_idle();
    check("t2_outs", out_seen - o0, 0);
    check("t2_code", last_code, 2'd0);
    check("t2_bad", bad_cnt, 32'd1);
    check("t2_gap", gap_seen, 0);

    // short: len 24, last on word 2
    run_frame(16'hA55A, 16'd2, 16'd24, 8'd2, 2);
    wait_idle();
    check("t3_code", last_code, 2'd1);

    // long: len 8, 3 words
    o0 = out_seen;
    run_frame(16'hA55A, 16'd3, 16'd8, 8'd4, 3);
    wait_idle();
    check("t4_outs", out_seen - o0, 1);
    check("t4_code", last_code, 2'd2);

    // empty good frame, oversize length, header-only short frame
    run_frame(16'hA55A, 16'd4, 16'd0, 8'd5, 0);
    run_frame(16'hA55A, 16'd5, 16'd8193, 8'd5, 1);
    run_frame(16'hA55A, 16'd6, 16'd10, 8'd6, 0);
    wait_idle();
    check("t5_code", last_code, 2'd1);
    check("t5_cnts", {good_cnt, bad_cnt}, {32'd2, 32'd5});

    // reset in the middle of a frame
    gap_q.push_back(1'b0);
    mdl_exp_seq = 16'd8;
    exp_q.push_back({8'd7, 16'd7, 1'b0, 1'b0, 8'hFF, pay_word(99, 0)});
    send_word({8'hEE, 8'd7, 16'd24, 16'd7, 16'hA55A}, 1'b0, 1'b1);
    send_word(pay_word(99, 0), 1'b0, 1'b0);
    wait_idle();
    sys_rst = 1'b1;
    mdl_have = 0; mdl_good = '0; mdl_bad = '0;
    st_q.delete(); gap_q.delete(); exp_q.delete();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst2_cnts", {good_cnt, bad_cnt, 1'b0, m_valid, frame_done}, '0);
    @(posedge sys_clk);
    #1;

    // sequence 5, 6, 8
    g0 = gap_seen;
    run_frame(16'hA55A, 16'd5, 16'd8, 8'd1, 1);
    run_frame(16'hA55A, 16'd6, 16'd8, 8'd1, 1);
    run_frame(16'hA55A, 16'd8, 16'd8, 8'd1, 1);
    wait_idle();
`ifdef UDP_RX_PARSER_SEQ_CHECK_EN
    check("seq_gaps", gap_seen - g0, 1);
`else
    check("seq_gaps", gap_seen - g0, 0);
`endif
    check("seq_good", good_cnt, 32'd3);

    // stalled output, 10-word frame followed back-to-back by another
    b0 = int'(good_cnt);
    rdy_mode = 1;
    run_frame(16'hA55A, 16'd9, 16'd80, 8'd8, 10);
    run_frame(16'hA55A, 16'd10, 16'd13, 8'd9, 2);
    wait_idle();
    rdy_mode = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("b2b_good", int'(good_cnt) - b0, 2);
    check("b2b_keep", last_keep, 8'h1F);

    check("end_queues", {exp_q.size(), st_q.size(), gap_q.size()}, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
